// File: rtl/irq_ctrl_if.sv
// Register access bus between a CPU-side master and the interrupt controller.
// Single-cycle request pulse; the slave acks one cycle later with read data.
interface irq_ctrl_if;
  logic        reg_req;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/irq_ctrl.sv
// Level-sensitive interrupt controller: per-source gateway, enable, priority and threshold onto one CPU irq.
// Register port acks one cycle after an accepted request; a request arriving during an ack cycle is dropped.
module irq_ctrl #(
  parameter int NSRC   = 4,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  irq_ctrl_if.slave       bus,
  output logic            irq_out,
  output logic [5:0]      claim_id
);

  localparam logic [5:0] W_ENABLE    = 6'd0;
  localparam logic [5:0] W_PENDING   = 6'd1;
  localparam logic [5:0] W_THRESHOLD = 6'd2;
  localparam logic [5:0] W_CLAIM     = 6'd3;
  localparam int         W_PRIO0     = 4;

  logic [NSRC-1:0]   enable_q, enable_d;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   inservice_q, inservice_d;
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  logic [PRIO_W-1:0] prio_q [NSRC];
  logic [PRIO_W-1:0] prio_d [NSRC];
  logic              ack_q, ack_d;
  logic              irq_q, irq_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [5:0]        word;
  logic [5:0]        win_id;
  logic [PRIO_W-1:0] win_prio;
  logic [31:0]       rd_word;
  logic              unused_bits;

  // A request coinciding with our own ack is silently dropped.
  assign accept      = bus.reg_req & ~ack_q;
  assign wr_en       = accept & bus.reg_we;
  assign rd_en       = accept & ~bus.reg_we;
  assign word        = bus.reg_addr[7:2];
  assign unused_bits = ^{bus.reg_addr[1:0], bus.reg_wdata};

  // Strict '>' against the running best keeps ties on the lowest index.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pending_q[i] && enable_q[i] && (prio_q[i] > threshold_q) && (prio_q[i] > win_prio)) begin
        win_id   = 6'(i + 1);
        win_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (word)
      W_ENABLE:    rd_word = 32'(enable_q);
      W_PENDING:   rd_word = 32'(pending_q);
      W_THRESHOLD: rd_word = 32'(threshold_q);
      W_CLAIM:     rd_word = 32'(win_id);
      default:     ;
    endcase
    for (int i = 0; i < NSRC; i++) begin
      if (word == 6'(W_PRIO0 + i)) rd_word = 32'(prio_q[i]);
    end
  end

  always_comb begin
    enable_d    = enable_q;
    threshold_d = threshold_q;
    prio_d      = prio_q;
    inservice_d = inservice_q;
    pending_d   = pending_q | (src_irq & ~inservice_q);

    if (wr_en) begin
      case (word)
        W_ENABLE:    enable_d    = bus.reg_wdata[NSRC-1:0];
        W_THRESHOLD: threshold_d = bus.reg_wdata[PRIO_W-1:0];
        W_CLAIM: begin
          for (int i = 0; i < NSRC; i++) begin
            if ((bus.reg_wdata[5:0] == 6'(i + 1)) && inservice_q[i]) inservice_d[i] = 1'b0;
          end
        end
        default: ;
      endcase
      for (int i = 0; i < NSRC; i++) begin
        if (word == 6'(W_PRIO0 + i)) prio_d[i] = bus.reg_wdata[PRIO_W-1:0];
      end
    end

    // Claim overrides a same-cycle gateway set on the claimed source.
    if (rd_en && (word == W_CLAIM)) begin
      for (int i = 0; i < NSRC; i++) begin
        if (win_id == 6'(i + 1)) begin
          pending_d[i]   = 1'b0;
          inservice_d[i] = 1'b1;
        end
      end
    end

    ack_d   = accept;
    rdata_d = rd_en ? rd_word : '0;
    irq_d   = (win_id != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q    <= '0;
      pending_q   <= '0;
      inservice_q <= '0;
      threshold_q <= '0;
      for (int i = 0; i < NSRC; i++) prio_q[i] <= '0;
      ack_q       <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      threshold_q <= threshold_d;
      prio_q      <= prio_d;
      ack_q       <= ack_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.reg_ack   = ack_q;
  assign bus.reg_rdata = rdata_q;
  assign irq_out       = irq_q;
  assign claim_id      = win_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: gateway, arbitration, threshold, handshake and async reset.
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] src_irq = '0;
  logic       irq_out;
  logic [5:0] claim_id;
  logic [31:0] d;
  int n_chk  = 0;
  int n_pass = 0;
  int seen;

  irq_ctrl_if bus();

  irq_ctrl #(.NSRC(4), .PRIO_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_irq  (src_irq),
    .bus      (bus),
    .irq_out  (irq_out),
    .claim_id (claim_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.reg_req = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = wd;
    @(posedge clk); #1;
    bus.reg_req = 1'b0; bus.reg_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] rv);
    @(posedge clk); #1;
    bus.reg_req = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = a;
    @(posedge clk); #1;
    bus.reg_req = 1'b0;
    @(negedge clk);
    chk("rd_ack", 32'(bus.reg_ack), 32'd1);
    rv = bus.reg_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.reg_req = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    @(negedge clk);
    chk("rst_irq",   32'(irq_out),       32'd0);
    chk("rst_claim", 32'(claim_id),      32'd0);
    chk("rst_ack",   32'(bus.reg_ack),   32'd0);
    chk("rst_rdata", bus.reg_rdata,      32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Basic path
    wr(8'h10, 32'd1);
    wr(8'h00, 32'h1);
    @(posedge clk); #1; src_irq = 4'b0001;
    @(posedge clk); #1; src_irq = 4'b0000;
    @(negedge clk);
    chk("basic_claim_id", 32'(claim_id), 32'd1);
    chk("basic_irq_early", 32'(irq_out), 32'd0);
    @(negedge clk);
    chk("basic_irq_rise", 32'(irq_out), 32'd1);
    rd(8'h04, d); chk("basic_pending", d, 32'h1);
    rd(8'h0C, d); chk("basic_claim_rd", d, 32'd1);
    chk("basic_irq_hold", 32'(irq_out), 32'd1);
    @(negedge clk);
    chk("basic_irq_fall", 32'(irq_out), 32'd0);
    rd(8'h04, d); chk("basic_pending_clr", d, 32'h0);
    wr(8'h0C, 32'd1);

    // Priority and tie-break
    wr(8'h10, 32'd1); wr(8'h14, 32'd5); wr(8'h18, 32'd5); wr(8'h1C, 32'd2);
    wr(8'h00, 32'hF);
    @(posedge clk); #1; src_irq = 4'hF;
    @(negedge clk); @(negedge clk);
    chk("prio_claim_id", 32'(claim_id), 32'd2);
    rd(8'h0C, d); chk("prio_claim1", d, 32'd2);
    rd(8'h0C, d); chk("prio_claim2", d, 32'd3);
    rd(8'h0C, d); chk("prio_claim3", d, 32'd4);
    rd(8'h0C, d); chk("prio_claim4", d, 32'd1);
    chk("prio_all_inservice", 32'(claim_id), 32'd0);
    src_irq = 4'h0;
    for (int k = 1; k <= 4; k++) wr(8'h0C, 32'(k));
    rd(8'h04, d); chk("prio_pending_clr", d, 32'h0);

    // Threshold masking and disable
    wr(8'h14, 32'd3);
    wr(8'h08, 32'd3);
    @(posedge clk); #1; src_irq = 4'b0010;
    @(posedge clk); #1; src_irq = 4'b0000;
    @(negedge clk); @(negedge clk);
    chk("thr_masked_irq", 32'(irq_out), 32'd0);
    rd(8'h04, d); chk("thr_pending", d, 32'h2);
    wr(8'h08, 32'd2);
    chk("thr_claim_id", 32'(claim_id), 32'd2);
    @(negedge clk);
    chk("thr_irq_rise", 32'(irq_out), 32'd1);
    wr(8'h00, 32'h0);
    chk("dis_claim_id", 32'(claim_id), 32'd0);
    chk("dis_irq_hold", 32'(irq_out), 32'd1);
    @(negedge clk);
    chk("dis_irq_fall", 32'(irq_out), 32'd0);
    rd(8'h04, d); chk("dis_pending_kept", d, 32'h2);
    wr(8'h00, 32'hF);
    rd(8'h0C, d); chk("thr_claim_rd", d, 32'd2);
    wr(8'h0C, 32'd2);
    wr(8'h08, 32'd0);

    // Gateway: held source, bad completes, real complete
    @(posedge clk); #1; src_irq = 4'b0001;
    rd(8'h0C, d); chk("gw_claim", d, 32'd1);
    rd(8'h04, d); chk("gw_pending_blocked", d, 32'h0);
    wr(8'h0C, 32'd5);
    wr(8'h0C, 32'd2);
    rd(8'h04, d); chk("gw_bad_complete", d, 32'h0);
    wr(8'h0C, 32'd1);
    chk("gw_cpl_same_edge", 32'(claim_id), 32'd0);
    @(negedge clk);
    chk("gw_cpl_next_edge", 32'(claim_id), 32'd1);
    rd(8'h04, d); chk("gw_pending_set", d, 32'h1);
    src_irq = 4'b0000;
    rd(8'h0C, d); chk("gw_reclaim", d, 32'd1);
    wr(8'h0C, 32'd1);

    // Handshake: back-to-back requests, unmapped read
    @(posedge clk); #1;
    bus.reg_req = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = 8'h08; bus.reg_wdata = 32'd1;
    @(posedge clk); #1;
    bus.reg_wdata = 32'd6;
    @(negedge clk);
    chk("b2b_first_ack", 32'(bus.reg_ack), 32'd1);
    @(posedge clk); #1;
    bus.reg_req = 1'b0; bus.reg_we = 1'b0;
    @(negedge clk);
    chk("b2b_second_ack", 32'(bus.reg_ack), 32'd0);
    rd(8'h08, d); chk("b2b_threshold", d, 32'd1);
    rd(8'h40, d); chk("unmapped_rd", d, 32'h0);
    rd(8'h00, d); chk("enable_rd", d, 32'hF);
    wr(8'h08, 32'd0);

    // Async reset mid-access
    @(posedge clk); #1; src_irq = 4'hF;
    rd(8'h04, d); chk("rst_pre_pending", d, 32'hF);
    @(negedge clk);
    chk("rst_pre_irq", 32'(irq_out), 32'd1);
    @(posedge clk); #1;
    bus.reg_req = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = 8'h0C;
    #2; rst = 1'b1; src_irq = 4'h0;
    #1;
    chk("arst_irq",   32'(irq_out),     32'd0);
    chk("arst_claim", 32'(claim_id),    32'd0);
    chk("arst_ack",   32'(bus.reg_ack), 32'd0);
    chk("arst_rdata", bus.reg_rdata,    32'd0);
    bus.reg_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.reg_ack) seen++;
    end
    chk("arst_no_ack", 32'(seen), 32'd0);
    rd(8'h04, d); chk("arst_pending", d, 32'h0);
    rd(8'h00, d); chk("arst_enable", d, 32'h0);
    rd(8'h10, d); chk("arst_prio0", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
